pool_map_buffer: RTL and testbench
==================================

Name: pool_map_buffer

Overview:
- Sits directly downstream of the 2x2 pooling stage.
- Collects the 12-element pooled columns, which arrive as irregular single-cycle valid pulses, into complete 12x12 feature maps.
- Streams each finished map, one column per beat with a ready/valid handshake, to the next convolution stage.
- Ping-pong (two-bank) storage: a new map can be filled while the previous one drains.

Parameters:
ROWS, 12, pooled values per column (pooled map height)
COLS, 12, columns per feature map (pooled map width)
DATA_W, 16, bits per pooled value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
valid_in  input  1  input_column holds a valid pooled column this cycle
input_column  input  ROWS x DATA_W (packed [ROWS-1:0][DATA_W-1:0])  pooled column; element r = map row r
in_ready  output  1  write bank not full; informational only, upstream cannot stall
overflow  output  1  sticky: a valid_in column was dropped
frame_done  output  1  one-cycle pulse: a bank just became full
out_valid  output  1  output_column holds a valid column of a full map
out_ready  input  1  downstream accepts the current column
output_column  output  ROWS x DATA_W  current output column
out_col_idx  output  clog2(COLS)  column index of output_column within its map
out_last  output  1  out_valid and out_col_idx == COLS-1

Behaviour:
- Reset: asynchronous, active-high. Clock and reset are clk and rst.
- Reset values: wr_bank=0, wr_col=0, rd_bank=0, rd_col=0, full[1:0]=0. Outputs: in_ready=1, overflow=0, frame_done=0, out_valid=0, out_col_idx=0, out_last=0.
- Bank contents are not reset. output_column is forced to 0 whenever out_valid=0.
- in_ready is combinational: !full[wr_bank].
- Write acceptance: valid_in && in_ready.
  - Column is stored at bank[wr_bank][wr_col]; wr_col increments.
  - When wr_col == COLS-1 is accepted: wr_col wraps to 0, full[wr_bank] is set, wr_bank toggles, and frame_done is asserted on the following cycle for exactly one cycle.
- Dropped write: valid_in && !in_ready.
  - Column is dropped; wr_col and the bank are unchanged.
  - overflow is set and stays 1 until reset.
- Read side:
  - out_valid = full[rd_bank], registered state, so out_valid rises the cycle after the edge that wrote the last column (write-to-read latency 1 cycle).
  - output_column = bank[rd_bank][rd_col]; out_col_idx = rd_col.
- Read transfer: out_valid && out_ready.
  - rd_col increments.
  - On the transfer with rd_col == COLS-1: rd_col wraps to 0, full[rd_bank] clears, rd_bank toggles.
- While out_valid && !out_ready: output_column, out_col_idx and out_last are held stable.
- Throughput: 1 column/cycle on each side, concurrently.
- Simultaneous events:
  - A write completing one bank and a read finishing the other bank on the same edge both take effect.
  - A read clearing full[b] on the same edge that valid_in targets wr_bank == b: the write is dropped (in_ready was 0 that cycle) and overflow is set. The bank is writable from the next cycle.
- Ordering: maps are emitted in fill order. Banks alternate strictly 0,1,0,1...
- Both banks full: in_ready=0 until the first read of bank rd_bank completes a full map.
- Reset mid-fill or mid-drain: partial maps are discarded. The next accepted column becomes column 0 of bank 0.

Decomposition:
- Shared package cnn_pkg holds:
  - typedef pixel_t (logic [DATA_W-1:0])
  - constants POOL_ROWS=12, POOL_COLS=12
  - column typedef pool_col_t (pixel_t [POOL_ROWS-1:0])
- One sub-module, pool_map_bank: a single COLS x ROWS x DATA_W register file with one write-column port and one combinational read-column port. It is instantiated twice.
- The bank/column pointers, full flags and handshake logic stay in pool_map_buffer.

Test Plan:
1. Single map: after reset, send 12 columns (valid_in gaps of 1 cycle), element r of column c = 16*c+r, with out_ready=1. Required response:
   - frame_done pulses once, one cycle after the 12th write.
   - out_valid rises the same cycle.
   - 12 beats with idx 0..11 and matching values; out_last only on idx 11.
   - overflow=0.
2. Backpressure: map from test 1 with out_ready toggling 1,0,1,0. Required response: output_column and idx hold during out_ready=0; exactly 12 transfers; no repeats or skips.
3. Both banks full: 24 columns back-to-back with out_ready=0, then a 25th column (value 0xFFFF). Required response:
   - in_ready=0 after column 24; the 25th is dropped; overflow=1.
   - Drain outputs bank-0 map then bank-1 map intact, with no 0xFFFF.
   - overflow stays 1 until reset.
4. Continuous streaming: 5 maps written at 1 column/cycle with out_ready=1. Required response: no overflow, 60 output beats in order, frame_done pulses 5 times.
5. Reset mid-fill: assert rst after 5 columns. Required response: all outputs return to their reset values immediately; the next 12 columns form a fresh map emitted at idx 0 with correct data.
6. Collision: both banks full; out_ready=1 such that the final read of bank 0 coincides with valid_in. Required response: that column is dropped, overflow=1, and a valid_in the following cycle is accepted into bank 0 at column 0.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared pooled-map types and dimensions for the CNN datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int POOL_ROWS   = 12;
  localparam int POOL_COLS   = 12;
  localparam int POOL_DATA_W = 16;

  typedef logic [POOL_DATA_W-1:0] pixel_t;
  typedef pixel_t [POOL_ROWS-1:0] pool_col_t;

  // Index width that stays at least 1 bit for degenerate single-column maps.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_map_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : pool_map_buffer_if
// Description : Column-in / column-out bundle of the pooled map buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pool_map_buffer_if
  import cnn_pkg::*;
#(
  parameter int ROWS   = POOL_ROWS,
  parameter int COLS   = POOL_COLS,
  parameter int DATA_W = POOL_DATA_W
);
  localparam int c_IDX_W = idx_width(COLS);

  logic                         valid_in;
  logic [ROWS-1:0][DATA_W-1:0]  input_column;
  logic                         in_ready;
  logic                         overflow;
  logic                         frame_done;
  logic                         out_valid;
  logic                         out_ready;
  logic [ROWS-1:0][DATA_W-1:0]  output_column;
  logic [c_IDX_W-1:0]           out_col_idx;
  logic                         out_last;

  modport master (
    output valid_in, input_column, out_ready,
    input  in_ready, overflow, frame_done, out_valid, output_column,
           out_col_idx, out_last
  );

  modport slave (
    input  valid_in, input_column, out_ready,
    output in_ready, overflow, frame_done, out_valid, output_column,
           out_col_idx, out_last
  );
endinterface
`default_nettype wire

// File: rtl/pool_map_bank.sv
`default_nettype none
// ============================================================================
// Module      : pool_map_bank
// Description : One COLS x ROWS x DATA_W map store, column write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_map_bank
  import cnn_pkg::*;
#(
  parameter int ROWS   = POOL_ROWS,
  parameter int COLS   = POOL_COLS,
  parameter int DATA_W = POOL_DATA_W,
  parameter int IDX_W  = idx_width(COLS)
)(
  input  logic                        clk,
  input  logic                        i_wr_en,
  input  logic [IDX_W-1:0]            i_wr_col,
  input  logic [ROWS-1:0][DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]            i_rd_col,
  output logic [ROWS-1:0][DATA_W-1:0] o_rd_data
);

  // Contents are deliberately left unreset; validity is tracked by the owner.
  logic [ROWS-1:0][DATA_W-1:0] r_mem [COLS];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_col] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_col];

endmodule
`default_nettype wire

// File: rtl/pool_map_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pool_map_buffer
// Description : Ping-pong collector of pooled columns into full maps, drained
//               one column per ready/valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_map_buffer
  import cnn_pkg::*;
#(
  parameter int ROWS   = POOL_ROWS,
  parameter int COLS   = POOL_COLS,
  parameter int DATA_W = POOL_DATA_W
)(
  input  logic             clk,
  input  logic             rst,
  pool_map_buffer_if.slave bus
);

  localparam int                 c_IDX_W    = idx_width(COLS);
  localparam logic [c_IDX_W-1:0] c_LAST_COL = c_IDX_W'(COLS - 1);

  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [c_IDX_W-1:0] r_wr_col;
  logic [c_IDX_W-1:0] r_rd_col;
  logic [1:0]         r_full;
  logic               r_overflow;
  logic               r_frame_done;

  logic               w_in_ready;
  logic               w_wr_fire;
  logic               w_wr_last;
  logic               w_out_valid;
  logic               w_rd_fire;
  logic               w_rd_last;
  logic [1:0]         w_full_nxt;

  logic [ROWS-1:0][DATA_W-1:0] w_bank_rd [2];

  assign w_in_ready  = !r_full[r_wr_bank];
  assign w_wr_fire   = bus.valid_in && w_in_ready;
  assign w_wr_last   = w_wr_fire && (r_wr_col == c_LAST_COL);
  assign w_out_valid = r_full[r_rd_bank];
  assign w_rd_fire   = w_out_valid && bus.out_ready;
  assign w_rd_last   = w_rd_fire && (r_rd_col == c_LAST_COL);

  // Set and clear never hit the same bank: a bank being written is not full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_col     <= '0;
      r_rd_col     <= '0;
      r_full       <= 2'b00;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_col  <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_col  <= r_wr_col + 1'b1;
        end
      end
      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_col  <= '0;
          r_rd_bank <= !r_rd_bank;
        end else begin
          r_rd_col  <= r_rd_col + 1'b1;
        end
      end
      r_full       <= w_full_nxt;
      r_frame_done <= w_wr_last;
      if (bus.valid_in && !w_in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pool_map_bank #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .DATA_W (DATA_W),
      .IDX_W  (c_IDX_W)
    ) u_bank (
      .clk       (clk),
      .i_wr_en   (w_wr_fire && (r_wr_bank == 1'(b))),
      .i_wr_col  (r_wr_col),
      .i_wr_data (bus.input_column),
      .i_rd_col  (r_rd_col),
      .o_rd_data (w_bank_rd[b])
    );
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.overflow      = r_overflow;
  assign bus.frame_done    = r_frame_done;
  assign bus.out_valid     = w_out_valid;
  assign bus.output_column = w_out_valid ? w_bank_rd[r_rd_bank] : '0;
  assign bus.out_col_idx   = r_rd_col;
  assign bus.out_last      = w_out_valid && (r_rd_col == c_LAST_COL);

endmodule
`default_nettype wire

// File: tb/tb_pool_map_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_map_buffer
// Description : Scoreboard bench for pool_map_buffer against a map-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_map_buffer;
  import cnn_pkg::*;

  localparam int ROWS   = 12;
  localparam int COLS   = 12;
  localparam int DATA_W = 16;
  localparam int CW     = ROWS * DATA_W;

  typedef logic [ROWS-1:0][DATA_W-1:0] col_t;
  typedef struct {
    col_t col;
    int   idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_map_buffer_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) bus();

  pool_map_buffer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Map-level model: completed maps wait as whole column lists, at most two.
  col_t  m_partial[$];
  beat_t exp_q[$];
  int    m_full  = 0;
  bit    m_ov    = 1'b0;
  bit    m_fd    = 1'b0;
  bit    m_acc;
  bit    m_dec;
  int    fd_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_partial.delete();
        exp_q.delete();
        m_full = 0;
        m_ov   = 1'b0;
        m_fd   = 1'b0;
      end else begin
        m_acc = (m_full < 2);
        m_dec = 1'b0;
        chk("in_ready",   CW'(bus.in_ready),   CW'(m_acc));
        chk("out_valid",  CW'(bus.out_valid),  CW'(m_full > 0));
        chk("frame_done", CW'(bus.frame_done), CW'(m_fd));
        chk("overflow",   CW'(bus.overflow),   CW'(m_ov));
        if (bus.frame_done) fd_seen++;
        if (m_full > 0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: out_valid with no expected column at %0t", $time);
          end else begin
            chk("out_col",  CW'(bus.output_column), CW'(exp_q[0].col));
            chk("out_idx",  CW'(bus.out_col_idx),   CW'(exp_q[0].idx));
            chk("out_last", CW'(bus.out_last),      CW'(exp_q[0].idx == COLS - 1));
            if (bus.out_ready) begin
              if (exp_q[0].idx == COLS - 1) m_dec = 1'b1;
              void'(exp_q.pop_front());
            end
          end
        end else begin
          chk("idle_col",  CW'(bus.output_column), CW'(0));
          chk("idle_last", CW'(bus.out_last),      CW'(0));
        end
        m_fd = 1'b0;
        if (bus.valid_in) begin
          if (m_acc) begin
            m_partial.push_back(bus.input_column);
            if (m_partial.size() == COLS) begin
              for (int c = 0; c < COLS; c++) exp_q.push_back('{m_partial[c], c});
              m_partial.delete();
              m_full++;
              m_fd = 1'b1;
            end
          end else begin
            m_ov = 1'b1;
          end
        end
        if (m_dec) m_full--;
      end
    end
  end

  // out_ready policy: 0 always 1, 1 toggle, 2 always 0, 3 left to the test.
  int rmode = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    case (rmode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = !bus.out_ready;
      2: bus.out_ready = 1'b0;
      default: ;
    endcase
  endtask

  function automatic col_t rand_col();
    col_t c;
    for (int r = 0; r < ROWS; r++) c[r] = DATA_W'($urandom);
    return c;
  endfunction

  function automatic col_t pat_col(input int c);
    col_t v;
    for (int r = 0; r < ROWS; r++) v[r] = DATA_W'(16 * c + r);
    return v;
  endfunction

  task automatic send(input col_t c, input int gap);
    bus.valid_in     = 1'b1;
    bus.input_column = c;
    cycle();
    bus.valid_in = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic drain(input string name);
    bus.valid_in = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && m_full == 0) break;
      cycle();
    end
    total++;
    if (!(exp_q.size() == 0 && m_full == 0)) begin
      bad++;
      $display("FAIL %s_drain_timeout: %0d columns left, want 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready",   CW'(bus.in_ready),      CW'(1));
    chk("rst_overflow",   CW'(bus.overflow),      CW'(0));
    chk("rst_frame_done", CW'(bus.frame_done),    CW'(0));
    chk("rst_out_valid",  CW'(bus.out_valid),     CW'(0));
    chk("rst_out_idx",    CW'(bus.out_col_idx),   CW'(0));
    chk("rst_out_last",   CW'(bus.out_last),      CW'(0));
    chk("rst_out_col",    CW'(bus.output_column), CW'(0));
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in     = 1'b0;
    bus.input_column = '0;
    bus.out_ready    = 1'b1;
    do_reset();

    // Single map with gapped writes, free-running sink.
    fd_seen = 0;
    rmode = 0;
    for (int c = 0; c < COLS; c++) send(pat_col(c), 1);
    drain("t1");
    chk("t1_fd_count", CW'(fd_seen), CW'(1));

    // Same map under alternating backpressure.
    rmode = 1;
    for (int c = 0; c < COLS; c++) send(pat_col(c), 1);
    drain("t2");

    // Both banks full, then an extra column that must be dropped.
    rmode = 2;
    for (int c = 0; c < 2 * COLS; c++) send(rand_col(), 0);
    chk("t3_in_ready_full", CW'(bus.in_ready), CW'(0));
    send({ROWS{16'hFFFF}}, 0);
    chk("t3_overflow", CW'(bus.overflow), CW'(1));
    rmode = 0;
    drain("t3");
    chk("t3_overflow_sticky", CW'(bus.overflow), CW'(1));
    do_reset();

    // Five maps streamed at full rate.
    fd_seen = 0;
    for (int c = 0; c < 5 * COLS; c++) send(rand_col(), 0);
    drain("t4");
    chk("t4_fd_count", CW'(fd_seen), CW'(5));
    chk("t4_overflow", CW'(bus.overflow), CW'(0));

    // Reset part-way through a fill, then a fresh map.
    for (int c = 0; c < 5; c++) send(rand_col(), 0);
    do_reset();
    for (int c = 0; c < COLS; c++) send(rand_col(), $urandom_range(0, 2));
    drain("t5");

    // Final read of bank 0 lands on the same edge as a write.
    rmode = 2;
    for (int c = 0; c < 2 * COLS; c++) send(rand_col(), 0);
    rmode = 3;
    bus.out_ready = 1'b1;
    repeat (COLS - 1) cycle();
    chk("t6_last_idx", CW'(bus.out_col_idx), CW'(COLS - 1));
    send(rand_col(), 0);
    chk("t6_overflow", CW'(bus.overflow), CW'(1));
    chk("t6_in_ready_after", CW'(bus.in_ready), CW'(1));
    for (int c = 0; c < COLS; c++) send(rand_col(), 0);
    rmode = 0;
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
